// File: rtl/ultrasonic_scheduler.sv
// Trigger/echo sequencer for an HC-SR04-style ranger with echo-to-centimetre conversion and repetition holdoff.
// Optional build macro ULTRASONIC_AVG_EN adds a 4-sample running average on distance_cm.
module ultrasonic_scheduler #(
   parameter int CLK_FREQ_HZ     = 100_000_000,
   parameter int TRIG_US         = 10,
   parameter int ECHO_TIMEOUT_US = 30000,
   parameter int PERIOD_MS       = 60,
   parameter int US_PER_CM       = 58,
   parameter int DIST_W          = 9
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              start,
   input  logic              echo,
   output logic              trigger,
   output logic [DIST_W-1:0] distance_cm,
   output logic              dist_valid,
   output logic              busy,
   output logic              timeout_err
);

   // state     | meaning
   // IDLE      | waiting for start or enable
   // TRIG      | trigger pulse high for TRIG_US
   // WAIT_RISE | waiting for a fresh echo rising edge
   // MEASURE   | echo high, accumulating centimetres
   // HOLDOFF   | waiting out the minimum repetition period
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_RISE = 3'd2,
      MEASURE   = 3'd3,
      HOLDOFF   = 3'd4
   } state_t;

   localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
   localparam int PRE_W      = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
   localparam int TMR_MAX    = (ECHO_TIMEOUT_US > TRIG_US) ? ECHO_TIMEOUT_US : TRIG_US;
   localparam int TMR_W      = $clog2(TMR_MAX + 1);
   localparam int SUB_W      = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
   localparam int MS_W       = $clog2(PERIOD_MS + 1);

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYC_PER_US - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
   localparam logic [TMR_W-1:0]  TMR_TRIG  = TMR_W'(TRIG_US);
   localparam logic [TMR_W-1:0]  TMR_ECHO  = TMR_W'(ECHO_TIMEOUT_US);
   localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(US_PER_CM - 1);
   localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(PERIOD_MS);
   localparam logic [DIST_W-1:0] ACC_MAX   = '1;

   state_t            state;
   logic              echo_s1, echo_s2, echo_d;
   logic              echo_rise, echo_fall;
   logic [PRE_W-1:0]  pre_cnt;
   logic              us_tick;
   logic [TMR_W-1:0]  tmr;
   logic [9:0]        ms_us;
   logic [MS_W-1:0]   ms_cnt;
   logic [SUB_W-1:0]  sub, sub_nxt;
   logic [DIST_W-1:0] acc, acc_nxt;
   logic [DIST_W-1:0] meas_val;

   assign us_tick   = (pre_cnt == PRE_LAST);
   assign echo_rise = echo_s2 & ~echo_d;
   assign echo_fall = ~echo_s2 & echo_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         echo_s1 <= 1'b0;
         echo_s2 <= 1'b0;
         echo_d  <= 1'b0;
      end else begin
         echo_s1 <= echo;
         echo_s2 <= echo_s1;
         echo_d  <= echo_s2;
      end
   end

   // The echo may fall on the same cycle as a us_tick; that tick must still count.
   always_comb begin
      sub_nxt = sub;
      acc_nxt = acc;
      if (us_tick) begin
         if (sub == SUB_LAST) begin
            sub_nxt = '0;
            if (acc != ACC_MAX) acc_nxt = acc + 1'b1;
         end else begin
            sub_nxt = sub + 1'b1;
         end
      end
   end

`ifdef ULTRASONIC_AVG_EN
   logic [DIST_W-1:0] hist [3];
   logic [DIST_W+1:0] avg_sum;

   assign avg_sum  = {2'b00, acc_nxt} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
   assign meas_val = avg_sum[DIST_W+1:2];
`else
   assign meas_val = acc_nxt;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         trigger     <= 1'b0;
         distance_cm <= '0;
         dist_valid  <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         pre_cnt     <= '0;
         tmr         <= '0;
         ms_us       <= '0;
         ms_cnt      <= '0;
         sub         <= '0;
         acc         <= '0;
`ifdef ULTRASONIC_AVG_EN
         hist[0]     <= '0;
         hist[1]     <= '0;
         hist[2]     <= '0;
`endif
      end else begin
         dist_valid <= 1'b0;
         pre_cnt    <= us_tick ? '0 : pre_cnt + 1'b1;

         // Period counter runs from trigger rise through holdoff and saturates at PERIOD_MS.
         if (state != IDLE && us_tick) begin
            if (ms_us == 10'd999) begin
               ms_us <= '0;
               if (ms_cnt != MS_LAST) ms_cnt <= ms_cnt + 1'b1;
            end else begin
               ms_us <= ms_us + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (start || enable) begin
                  state   <= TRIG;
                  trigger <= 1'b1;
                  busy    <= 1'b1;
                  pre_cnt <= '0;
                  tmr     <= TMR_TRIG;
                  ms_us   <= '0;
                  ms_cnt  <= '0;
               end
            end
            TRIG: begin
               if (us_tick) begin
                  if (tmr == TMR_ONE) begin
                     state   <= WAIT_RISE;
                     trigger <= 1'b0;
                     pre_cnt <= '0;
                     tmr     <= TMR_ECHO;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
            end
            WAIT_RISE: begin
               if (echo_rise) begin
                  state   <= MEASURE;
                  pre_cnt <= '0;
                  sub     <= '0;
                  acc     <= '0;
                  tmr     <= TMR_ECHO;
               end else if (us_tick) begin
                  if (tmr == TMR_ONE) begin
                     state       <= HOLDOFF;
                     pre_cnt     <= '0;
                     timeout_err <= 1'b1;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
            end
            MEASURE: begin
               sub <= sub_nxt;
               acc <= acc_nxt;
               if (echo_fall) begin
                  state       <= HOLDOFF;
                  pre_cnt     <= '0;
                  distance_cm <= meas_val;
                  dist_valid  <= 1'b1;
                  timeout_err <= 1'b0;
`ifdef ULTRASONIC_AVG_EN
                  hist[0]     <= acc_nxt;
                  hist[1]     <= hist[0];
                  hist[2]     <= hist[1];
`endif
               end else if (us_tick) begin
                  if (tmr == TMR_ONE) begin
                     state       <= HOLDOFF;
                     pre_cnt     <= '0;
                     timeout_err <= 1'b1;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
            end
            HOLDOFF: begin
               if (ms_cnt == MS_LAST) begin
                  pre_cnt <= '0;
                  if (enable) begin
                     state   <= TRIG;
                     trigger <= 1'b1;
                     tmr     <= TMR_TRIG;
                     ms_us   <= '0;
                     ms_cnt  <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               trigger <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler using scaled-down timing (2 clk/us, 2 ms period).
// Expected distances follow ULTRASONIC_AVG_EN when the build defines it.
module tb_ultrasonic_scheduler;

   localparam int CYC     = 2;
   localparam int TRIG    = 10;
   localparam int TMO     = 600;
   localparam int PER_MS  = 2;
   localparam int USCM    = 10;
   localparam int DW      = 9;
   localparam int PER_LO  = PER_MS * 1000 * CYC;
   localparam int PER_HI  = PER_LO + 4;

   typedef struct {
      int delay_us;
      int width_us;
      bit stale;
      int exp_raw;
      bit exp_valid;
      bit exp_err;
   } shot_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          start = 1'b0;
   logic          echo = 1'b0;
   logic          trigger;
   logic [DW-1:0] distance_cm;
   logic          dist_valid;
   logic          busy;
   logic          timeout_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int valid_cnt = 0;
   int trig_rises = 0;
   logic trig_prev = 1'b0;
   int exp_dist = 0;
   int exp_err = 0;
   int hist_m [3];
   shot_t shots [8];
   shot_t avg_shots [4];

   ultrasonic_scheduler #(
      .CLK_FREQ_HZ(CYC * 1_000_000),
      .TRIG_US(TRIG),
      .ECHO_TIMEOUT_US(TMO),
      .PERIOD_MS(PER_MS),
      .US_PER_CM(USCM),
      .DIST_W(DW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .enable(enable),
      .start(start),
      .echo(echo),
      .trigger(trigger),
      .distance_cm(distance_cm),
      .dist_valid(dist_valid),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dist_valid) valid_cnt <= valid_cnt + 1;
      if (trigger && !trig_prev) trig_rises <= trig_rises + 1;
      trig_prev <= trigger;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic model_reset();
      exp_dist = 0;
      exp_err  = 0;
      for (int i = 0; i < 3; i++) hist_m[i] = 0;
   endtask

   task automatic model_good(input int raw);
`ifdef ULTRASONIC_AVG_EN
      exp_dist  = (raw + hist_m[0] + hist_m[1] + hist_m[2]) / 4;
      hist_m[2] = hist_m[1];
      hist_m[1] = hist_m[0];
      hist_m[0] = raw;
`else
      exp_dist = raw;
`endif
      exp_err = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_level(input string name, input logic want_trig, input int budget);
      int n = 0;
      while (trigger != want_trig && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (trigger != want_trig) check({name, " timed out"}, int'(trigger), int'(want_trig));
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy) check({name, " busy stuck"}, int'(busy), 0);
   endtask

   task automatic run_shot(input shot_t s, input string tag);
      int v0, t0, w;
      v0 = valid_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_level({tag, " trig rise"}, 1'b1, 50);
      t0 = cyc;
      if (s.stale) echo = 1'b1;
      w = 0;
      while (trigger && w < 200) begin
         @(negedge clk);
         w++;
      end
      check({tag, " trigger width"}, w, TRIG * CYC);
      repeat (s.delay_us * CYC) @(negedge clk);
      if (s.width_us > 0) begin
         echo = 1'b1;
         repeat (s.width_us * CYC) @(negedge clk);
         echo = 1'b0;
      end
      wait_idle(tag, 6000);
      check_range({tag, " busy span"}, cyc - t0, PER_LO, PER_HI);
      if (s.exp_valid) model_good(s.exp_raw);
      else if (s.exp_err) exp_err = 1;
      check({tag, " valid pulses"}, valid_cnt - v0, int'(s.exp_valid));
      check({tag, " distance"}, int'(distance_cm), exp_dist);
      check({tag, " timeout_err"}, int'(timeout_err), exp_err);
   endtask

   initial begin
      int v0, r0, t0, t1;
      model_reset();
      shots[0] = '{200, 100, 1'b0, 10, 1'b1, 1'b0};
      shots[1] = '{50,  0,   1'b0, 0,  1'b0, 1'b1};
      shots[2] = '{30,  100, 1'b0, 10, 1'b1, 1'b0};
      shots[3] = '{10,  255, 1'b0, 25, 1'b1, 1'b0};
      shots[4] = '{20,  700, 1'b0, 0,  1'b0, 1'b1};
      shots[5] = '{40,  420, 1'b0, 42, 1'b1, 1'b0};
      shots[6] = '{0,   700, 1'b1, 0,  1'b0, 1'b1};
      shots[7] = '{100, 300, 1'b0, 30, 1'b1, 1'b0};
      avg_shots[0] = '{20, 100, 1'b0, 10, 1'b1, 1'b0};
      avg_shots[1] = '{20, 200, 1'b0, 20, 1'b1, 1'b0};
      avg_shots[2] = '{20, 300, 1'b0, 30, 1'b1, 1'b0};
      avg_shots[3] = '{20, 400, 1'b0, 40, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      check("reset trigger", int'(trigger), 0);
      check("reset distance", int'(distance_cm), 0);
      check("reset dist_valid", int'(dist_valid), 0);
      check("reset busy", int'(busy), 0);
      check("reset timeout_err", int'(timeout_err), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) run_shot(shots[i], $sformatf("shot%0d", i));

      do_reset();
      for (int i = 0; i < 4; i++) run_shot(avg_shots[i], $sformatf("avg%0d", i));

      // continuous mode: two periods, enable dropped during the second echo
      v0 = valid_cnt;
      r0 = trig_rises;
      @(negedge clk) enable = 1'b1;
      wait_level("cont rise0", 1'b1, 50);
      t0 = cyc;
      wait_level("cont fall0", 1'b0, 100);
      repeat (200 * CYC) @(negedge clk);
      echo = 1'b1;
      repeat (200 * CYC) @(negedge clk);
      echo = 1'b0;
      wait_level("cont rise1", 1'b1, 6000);
      t1 = cyc;
      check_range("cont spacing", t1 - t0, PER_LO, PER_HI);
      model_good(20);
      check("cont dist0", int'(distance_cm), exp_dist);
      check("cont err0", int'(timeout_err), 0);
      wait_level("cont fall1", 1'b0, 100);
      repeat (200 * CYC) @(negedge clk);
      echo = 1'b1;
      repeat (10) @(negedge clk);
      enable = 1'b0;
      repeat (500 * CYC - 10) @(negedge clk);
      echo = 1'b0;
      wait_idle("cont end", 6000);
      model_good(50);
      check("cont dist1", int'(distance_cm), exp_dist);
      check("cont valid pulses", valid_cnt - v0, 2);
      check("cont err1", int'(timeout_err), 0);
      repeat (300) @(negedge clk);
      check("cont trigger count", trig_rises - r0, 2);

      // reset in the middle of MEASURE
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_level("rstm rise", 1'b1, 50);
      wait_level("rstm fall", 1'b0, 100);
      repeat (20) @(negedge clk);
      echo = 1'b1;
      repeat (100) @(negedge clk);
      check("rstm busy before", int'(busy), 1);
      check("rstm distance before", int'(distance_cm), exp_dist);
      reset_n = 1'b0;
      #1;
      check("rstm trigger", int'(trigger), 0);
      check("rstm distance", int'(distance_cm), 0);
      check("rstm dist_valid", int'(dist_valid), 0);
      check("rstm busy", int'(busy), 0);
      check("rstm timeout_err", int'(timeout_err), 0);
      @(negedge clk) echo = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);

      // reset in the middle of TRIG
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_level("rstt rise", 1'b1, 50);
      repeat (5) @(negedge clk);
      check("rstt trigger before", int'(trigger), 1);
      reset_n = 1'b0;
      #1;
      check("rstt trigger", int'(trigger), 0);
      check("rstt busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);

      // start while busy must not queue a second measurement
      r0 = trig_rises;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_level("busy rise", 1'b1, 50);
      wait_level("busy fall", 1'b0, 100);
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_idle("busy start", 6000);
      repeat (300) @(negedge clk);
      check("busy start ignored", trig_rises - r0, 1);
      check("busy start err", int'(timeout_err), 1);
      check("busy start distance", int'(distance_cm), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
